// File: rtl/pe_output_collector_pkg.sv
// Shared widths, precision encodings and FSM state type for the PE output collector.
package pe_output_collector_pkg;

  localparam int ACC_DATA_WIDTH = 32;
  localparam int ACT_DATA_WIDTH = 8;
  localparam int WORD_WIDTH     = 64;

  localparam logic [1:0] PREC_8B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_2B = 2'd2;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} collector_state_t;

endpackage

// File: rtl/pe_collect_fifo.sv
// Registered first-word-fall-through FIFO; the head entry is visible whenever !empty.
module pe_collect_fifo #(
  parameter int DATA_W = 81,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_output_collector.sv
// Truncates PE outputs to the layer precision, packs them LSB-first into words and queues them
// for the activation-memory writer. Define PE_COLLECT_STALL_CNT_EN to add the stall_cycles counter.
module pe_output_collector #(
  parameter int ACC_DATA_WIDTH = pe_output_collector_pkg::ACC_DATA_WIDTH,
  parameter int ACT_DATA_WIDTH = pe_output_collector_pkg::ACT_DATA_WIDTH,
  parameter int WORD_WIDTH     = pe_output_collector_pkg::WORD_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                PRECISION,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num_outputs,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic                      in_valid,
  input  logic [ACC_DATA_WIDTH-1:0] in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WORD_WIDTH-1:0]     out_data,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
`ifdef PE_COLLECT_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);
  import pe_output_collector_pkg::*;

  localparam int PW = $clog2(WORD_WIDTH / 2);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 1 + ADDR_WIDTH + WORD_WIDTH;

  collector_state_t      state;
  logic [1:0]            prec_q;
  logic [3:0]            lane_w;
  logic [PW-1:0]         p, p_max;
  logic [PW+3:0]         shamt;
  logic [WORD_WIDTH-1:0] pack, pack_next, lane_mask, lane_data;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  accept, last_elem, word_done, push;
  logic [EW-1:0]         pop_data;
  logic                  unused_in_hi;

  assign unused_in_hi = ^in_data[ACC_DATA_WIDTH-1:ACT_DATA_WIDTH];

  // 4-bit lanes also cover the redundant encoding 3
  always_comb begin
    lane_w = 4'd4;
    p_max  = PW'(WORD_WIDTH / 4 - 1);
    case (prec_q)
      PREC_8B: begin lane_w = 4'd8; p_max = PW'(WORD_WIDTH / 8 - 1); end
      PREC_2B: begin lane_w = 4'd2; p_max = PW'(WORD_WIDTH / 2 - 1); end
      default: ;
    endcase
  end

  assign lane_mask = (WORD_WIDTH'(1) << lane_w) - WORD_WIDTH'(1);
  assign lane_data = WORD_WIDTH'(in_data[ACT_DATA_WIDTH-1:0]) & lane_mask;
  assign shamt     = {4'd0, p} * {{PW{1'b0}}, lane_w};
  assign pack_next = pack | (lane_data << shamt);

  assign in_ready  = (state == COLLECT) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign last_elem = (remaining == CNT_WIDTH'(1));
  assign word_done = (p == p_max) || last_elem;
  assign push      = accept && word_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prec_q    <= PREC_8B;
      p         <= '0;
      pack      <= '0;
      remaining <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (num_outputs == '0) state <= DONE;
          else begin
            prec_q    <= PRECISION;
            remaining <= num_outputs;
            addr      <= base_addr;
            p         <= '0;
            pack      <= '0;
            busy      <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: if (accept) begin
          remaining <= remaining - CNT_WIDTH'(1);
          if (word_done) begin
            pack <= '0;
            p    <= '0;
            addr <= addr + ADDR_WIDTH'(1);
            if (last_elem) state <= DRAIN;
          end else begin
            pack <= pack_next;
            p    <= p + PW'(1);
          end
        end
        DRAIN: if (fifo_empty) begin
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pe_collect_fifo #(.DATA_W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({last_elem, addr, pack_next}),
    .pop       (out_valid && out_ready),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = pop_data[EW-1];
  assign out_addr  = pop_data[WORD_WIDTH +: ADDR_WIDTH];
  assign out_data  = pop_data[WORD_WIDTH-1:0];

`ifdef PE_COLLECT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (state == COLLECT && in_valid && !in_ready && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pe_output_collector.sv
// Directed bench for pe_output_collector: packing per precision, address wrap, backpressure, empty tile, abort.
module tb_pe_output_collector;

  logic        clk, reset;
  logic [1:0]  PRECISION;
  logic        start;
  logic [15:0] num_outputs, base_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [63:0] out_data;
  logic [15:0] out_addr;
  logic        busy, done;

  pe_output_collector dut (
    .clk(clk), .reset(reset), .PRECISION(PRECISION), .start(start),
    .num_outputs(num_outputs), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, ov_cnt = 0, busy_cnt = 0;
  int n_acc, pop_cyc, stall_bad;
  logic [31:0] elems [0:63];
  logic [63:0] got_d[$];
  logic [15:0] got_a[$];
  logic        got_l[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic producer(input int n);
    int  waitc;
    bit  ok;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = elems[i];
      ok = 1'b0;
      waitc = 0;
      while (!ok && waitc < 3000) begin
        ok = in_ready;
        @(posedge clk); #1;
        waitc++;
      end
      if (!ok) begin
        check("producer_timeout", 64'(i), 64'(n));
        in_valid = 1'b0;
        return;
      end
      n_acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consumer(input int hold, input int exp_acc);
    int c = 0;
    bit fin = 1'b0, held = 1'b0;
    logic [63:0] hd;
    logic [15:0] ha;
    logic        hl;
    while (!fin && c < 3000) begin
      out_ready = (c >= hold);
      if (hold > 0 && c == 10) begin
        num_outputs = 16'd0;
        start = 1'b1;
      end
      if (hold > 0 && c == 11) start = 1'b0;
      if (hold > 0 && c == hold) begin
        check("acc_at_release", 64'(n_acc), 64'(exp_acc));
        check("in_ready_when_full", 64'(in_ready), 64'd0);
      end
      if (held && (!out_valid || out_data !== hd || out_addr !== ha || out_last !== hl))
        stall_bad++;
      held = out_valid && !out_ready;
      hd = out_data; ha = out_addr; hl = out_last;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_a.push_back(out_addr);
        got_l.push_back(out_last);
        pop_cyc = cyc;
        if (out_last) fin = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    if (!fin) check("consumer_timeout", 64'(c), 64'd0);
  endtask

  task automatic run_tile(input logic [1:0] prec, input int n, input logic [15:0] base,
                          input int hold, input int exp_acc);
    int d0;
    got_d.delete(); got_a.delete(); got_l.delete();
    n_acc = 0; stall_bad = 0; pop_cyc = 0;
    d0 = done_cnt;
    PRECISION = prec; num_outputs = 16'(n); base_addr = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      producer(n);
      consumer(hold, exp_acc);
    join
    repeat (20) @(posedge clk);
    #1;
    check("stall_stable", 64'(stall_bad), 64'd0);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_after_tile", 64'(busy), 64'd0);
  endtask

  initial begin
    int d0, ov0, b0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    PRECISION = 2'd0; num_outputs = '0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_addr_last", {47'd0, out_last, out_addr}, 64'd0);

    // Elements offered while idle must be refused
    in_valid = 1'b1; in_data = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      check("idle_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // 8-bit lanes, one full word
    for (int i = 0; i < 8; i++) elems[i] = 32'(i + 1);
    run_tile(2'd0, 8, 16'h0010, 0, 0);
    check("t1_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      check("t1_data", got_d[0], 64'h0807060504030201);
      check("t1_addr", 64'(got_a[0]), 64'h10);
      check("t1_last", 64'(got_l[0]), 64'd1);
    end
    check("t1_done_after_pop", 64'(done_cyc > pop_cyc), 64'd1);

    // 4-bit lanes, partial word, upper input bits dropped
    for (int i = 0; i < 5; i++) elems[i] = 32'hFFFFFF00 | 32'(i + 1);
    run_tile(2'd1, 5, 16'h0020, 0, 0);
    check("t2_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      check("t2_data", got_d[0], 64'h0000000000054321);
      check("t2_addr", 64'(got_a[0]), 64'h20);
      check("t2_last", 64'(got_l[0]), 64'd1);
    end

    // 2-bit lanes, two words, address wraps
    for (int i = 0; i < 64; i++) elems[i] = (32'(i) << 8) | 32'(i % 4);
    run_tile(2'd2, 64, 16'hFFFF, 0, 0);
    check("t3_nwords", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      check("t3_data0", got_d[0], 64'hE4E4E4E4E4E4E4E4);
      check("t3_data1", got_d[1], 64'hE4E4E4E4E4E4E4E4);
      check("t3_addr0", 64'(got_a[0]), 64'hFFFF);
      check("t3_addr1", 64'(got_a[1]), 64'h0000);
      check("t3_last0", 64'(got_l[0]), 64'd0);
      check("t3_last1", 64'(got_l[1]), 64'd1);
    end

    // Backpressure: writer stalled until the FIFO fills; a start mid-tile is ignored
    for (int i = 0; i < 48; i++) elems[i] = 32'(i + 1);
    run_tile(2'd0, 48, 16'h0100, 60, 32);
    check("t4_nwords", 64'(got_d.size()), 64'd6);
    if (got_d.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8*k + j + 1);
        check($sformatf("t4_data%0d", k), got_d[k], w);
        check($sformatf("t4_addr%0d", k), 64'(got_a[k]), 64'(16'h0100 + 16'(k)));
        check($sformatf("t4_last%0d", k), 64'(got_l[k]), 64'(k == 5));
      end
    end

    // Empty tile
    d0 = done_cnt; ov0 = ov_cnt; b0 = busy_cnt;
    PRECISION = 2'd0; num_outputs = 16'd0; base_addr = 16'h0077; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_done_c1", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("t5_done_c2", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("t5_done_c3", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_valid", 64'(ov_cnt - ov0), 64'd0);
    check("t5_no_busy", 64'(busy_cnt - b0), 64'd0);
    check("t5_one_done", 64'(done_cnt - d0), 64'd1);

    // Abort after 3 of 8 elements, then a fresh tile
    d0 = done_cnt;
    PRECISION = 2'd0; num_outputs = 16'd8; base_addr = 16'h0040; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(8'hAA + 8'(i * 17));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("t6_busy_after_rst", 64'(busy), 64'd0);
    check("t6_valid_after_rst", 64'(out_valid), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_abort_done", 64'(done_cnt - d0), 64'd0);
    for (int i = 0; i < 8; i++) elems[i] = 32'(8'h11 + 8'(i));
    run_tile(2'd0, 8, 16'h0050, 0, 0);
    check("t6_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      check("t6_data", got_d[0], 64'h1817161514131211);
      check("t6_addr", 64'(got_a[0]), 64'h50);
      check("t6_last", 64'(got_l[0]), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
